des_round_engine: RTL and testbench

//  Iterative DES data path. Sits directly downstream of the round-key generator.

---
 rtl/des_pkg.sv | 68 ++++++
 rtl/des_sbox.sv | 49 ++++
 rtl/des_round_engine.sv | 96 +++++++++
 tb/tb_des_round_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES definitions: block widths, FSM encoding and the fixed bit permutations.
// Tables use DES numbering (bit 1 = MSB of the vector).
package des_pkg;

    localparam int BLOCK_W = 64;
    localparam int HALF_W  = 32;
    localparam int RKEY_W  = 48;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } state_t;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    function automatic logic [BLOCK_W-1:0] ip_perm(input logic [BLOCK_W-1:0] d);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - IP_TBL[i])];
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] fp_perm(input logic [BLOCK_W-1:0] d);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - FP_TBL[i])];
        return o;
    endfunction

    function automatic logic [RKEY_W-1:0] e_perm(input logic [HALF_W-1:0] d);
        logic [RKEY_W-1:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = d[5'(32 - E_TBL[i])];
        return o;
    endfunction

    function automatic logic [HALF_W-1:0] p_perm(input logic [HALF_W-1:0] d);
        logic [HALF_W-1:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[5'(31 - i)] = d[5'(32 - P_TBL[i])];
        return o;
    endfunction

endpackage

// File: rtl/des_sbox.sv
// One DES substitution box, selected by SBOX_SEL (1..8).
// Row comes from the outer address bits, column from the inner four.
module des_sbox
    import des_pkg::*;
#(
    parameter int SBOX_SEL = 1
) (
    input  logic [5:0] addr,
    output logic [3:0] val
);

    localparam int S_TBL [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    assign val = 4'(S_TBL[3'(SBOX_SEL - 1)][{addr[5], addr[0], addr[4:1]}]);

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES data path: one Feistel round per clock, 16 rounds per block.
// The round key arrives combinationally for the round_idx driven this cycle.
module des_round_engine
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               decrypt,
    input  logic [BLOCK_W-1:0] din,
    output logic [3:0]         round_idx,
    input  logic [RKEY_W-1:0]  round_key,
    output logic               busy,
    output logic               done,
    output logic [BLOCK_W-1:0] dout
);

    state_t              state, state_next;
    logic [3:0]          counter;
    logic                dec_mode;
    logic                last_round;
    logic [HALF_W-1:0]   l_half, r_half;
    logic [HALF_W-1:0]   s_out, f_out, r_next;
    logic [RKEY_W-1:0]   e_mix;
    logic [BLOCK_W-1:0]  ip_blk;

    assign round_idx  = busy ? (dec_mode ? 4'd15 - counter : counter) : 4'd0;
    assign last_round = busy && (counter == 4'(NUM_ROUNDS - 1));
    assign ip_blk     = ip_perm(din);

    // f-function: expand, mix key, substitute, permute
    assign e_mix = e_perm(r_half) ^ round_key;

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        des_sbox #(.SBOX_SEL(g + 1)) u_sbox (
            .addr (e_mix[47 - 6*g -: 6]),
            .val  (s_out[31 - 4*g -: 4])
        );
    end

    assign f_out  = p_perm(s_out);
    assign r_next = l_half ^ f_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (last_round) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Final round writes the swapped halves {R16, L16} through FP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_half   <= '0;
            r_half   <= '0;
            counter  <= 4'd0;
            dec_mode <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    l_half   <= ip_blk[BLOCK_W-1:HALF_W];
                    r_half   <= ip_blk[HALF_W-1:0];
                    dec_mode <= decrypt;
                    counter  <= 4'd0;
                end
            end else begin
                l_half  <= r_half;
                r_half  <= r_next;
                counter <= counter + 4'd1;
                if (last_round) begin
                    done <= 1'b1;
                    dout <= fp_perm({r_next, r_half});
                end
            end
        end
    end

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine with a behavioural DES key schedule
// answering round_idx in the same cycle.
module tb_des_round_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [63:0] din;
    logic [3:0]  round_idx;
    logic [47:0] round_key;
    logic        busy;
    logic        done;
    logic [63:0] dout;

    logic [47:0] sk [16];
    logic [63:0] exp_dout;
    int          n_tests;
    int          n_fail;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_round_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .decrypt   (decrypt),
        .din       (din),
        .round_idx (round_idx),
        .round_key (round_key),
        .busy      (busy),
        .done      (done),
        .dout      (dout)
    );

    assign round_key = sk[round_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - PC2[i])];
            sk[r] = k;
        end
    endtask

    // Starts a block in the current cycle and returns in its done cycle.
    task automatic run_block(input logic [63:0] blk, input logic dec, input int stray_at,
                             input logic [63:0] expv, input string tag);
        logic [63:0] idx_seq;
        int          k;
        int          busy_cnt;
        int          hold_err;
        idx_seq  = '0;
        busy_cnt = 0;
        hold_err = 0;
        start    = 1'b1;
        din      = blk;
        decrypt  = dec;
        tick();
        start   = 1'b0;
        din     = ~blk;
        decrypt = ~dec;
        k = 1;
        while (!done && k < 40) begin
            if (busy) begin
                busy_cnt++;
                idx_seq = {idx_seq[59:0], round_idx};
            end
            if (dout !== exp_dout) hold_err++;
            if (k == stray_at) begin
                start   = 1'b1;
                din     = 64'hDEAD_BEEF_0BAD_F00D;
                decrypt = ~dec;
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(k), 64'd17);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd16);
        check({tag, "_round_idx_seq"}, idx_seq,
              dec ? 64'hFEDC_BA98_7654_3210 : 64'h0123_4567_89AB_CDEF);
        check({tag, "_dout_hold"}, 64'(hold_err), 64'd0);
        check({tag, "_dout"}, dout, expv);
        exp_dout = expv;
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;
        int idx_err;
        int hold_err;
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        decrypt  = 1'b0;
        din      = '0;
        exp_dout = '0;
        for (int i = 0; i < 16; i++) sk[i] = '0;
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dout", dout, 64'd0);
        check("reset_round_idx", 64'(round_idx), 64'd0);
        rst = 1'b0;
        tick();

        load_key(64'h1334_5779_9BBC_DFF1);
        run_block(64'h0123_4567_89AB_CDEF, 1'b0, 0, 64'h85E8_1354_0F0A_B405, "enc1");
        run_block(64'h85E8_1354_0F0A_B405, 1'b1, 0, 64'h0123_4567_89AB_CDEF, "dec1");

        load_key(64'h0E32_9232_EA6D_0D73);
        run_block(64'h8787_8787_8787_8787, 1'b0, 0, 64'h0000_0000_0000_0000, "enc2");
        run_block(64'h0000_0000_0000_0000, 1'b1, 0, 64'h8787_8787_8787_8787, "b2b");

        load_key(64'h1334_5779_9BBC_DFF1);
        run_block(64'h0123_4567_89AB_CDEF, 1'b0, 5, 64'h85E8_1354_0F0A_B405, "stray");
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        check("stray_extra_done", 64'(done_cnt), 64'd0);
        check("stray_extra_busy", 64'(busy_cnt), 64'd0);

        start   = 1'b1;
        din     = 64'h0123_4567_89AB_CDEF;
        decrypt = 1'b0;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #3;
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_dout", dout, 64'd0);
        check("midrst_round_idx", 64'(round_idx), 64'd0);
        exp_dout = '0;
        tick();
        rst = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        check("postrst_done", 64'(done_cnt), 64'd0);
        check("postrst_busy", 64'(busy_cnt), 64'd0);
        run_block(64'h0123_4567_89AB_CDEF, 1'b0, 0, 64'h85E8_1354_0F0A_B405, "postrst");

        done_cnt = 0;
        idx_err  = 0;
        hold_err = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done) done_cnt++;
            if (round_idx != 4'd0) idx_err++;
            if (dout !== exp_dout) hold_err++;
        end
        check("idle_done", 64'(done_cnt), 64'd0);
        check("idle_round_idx", 64'(idx_err), 64'd0);
        check("idle_dout_hold", 64'(hold_err), 64'd0);
        check("idle_dout", dout, 64'h85E8_1354_0F0A_B405);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
